// File: rtl/vga_pkg.sv
// Shared timing constants, pixel layout and address helper for the
// framebuffer arbiter.
package vga_pkg;

  localparam logic [10:0] HMAX   = 11'd800;
  localparam logic [10:0] VMAX   = 11'd525;
  localparam logic [10:0] HLINES = 11'd640;
  localparam logic [10:0] VLINES = 11'd480;
  localparam logic [7:0]  FB_W   = 8'd160;

  // hcounter of the last in-line fetch: group FB_W-1 is fetched at 4k-3.
  localparam logic [10:0] LAST_SLOT_H = {1'b0, FB_W - 8'd2, 2'b01};

  // RRRGGGBB pixel: r = [7:5], g = [4:2], b = [1:0].
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } pixel_t;

  // Which requester owns the RAM port this cycle.
  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_DISP,
    OWN_CPU
  } ram_owner_t;

  // row*160 + col as shift-add: (row<<7) + (row<<5) + col.
  function automatic logic [15:0] fb_offset(input logic [8:0] row, input logic [7:0] col);
    return {row, 7'b0} + {2'b0, row, 5'b0} + {8'b0, col};
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// CPU-side request/acknowledge bus of the framebuffer arbiter.
interface vga_fb_arbiter_if #(
  parameter int AW = 15
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );

endinterface

// File: rtl/vga_fb_addr_gen.sv
// Decides from the scan position whether this cycle is a display fetch,
// and which framebuffer word that fetch reads.
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic [10:0]   hcounter,
  input  logic [10:0]   vcounter,
  output logic          display_slot,
  output logic [AW-1:0] display_addr
);

  logic [10:0] vnext;
  logic        slot_cur;
  logic        slot_next;

  // In-line slots prefetch groups 1..159; the slot at HMAX-2 prefetches
  // group 0 of the following line, wrapping VMAX back to row 0.
  always_comb begin
    vnext        = (vcounter == VMAX) ? 11'd0 : vcounter + 11'd1;
    slot_cur     = (vcounter < VLINES) && (hcounter[1:0] == 2'b01) &&
                   (hcounter <= LAST_SLOT_H);
    slot_next    = (hcounter == HMAX - 11'd2) && (vnext < VLINES);
    display_slot = slot_cur | slot_next;
    if (slot_next)
      display_addr = AW'(fb_offset(vnext[10:2], 8'd0));
    else
      display_addr = AW'(fb_offset(vcounter[10:2], hcounter[9:2] + 8'd1));
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port synchronous framebuffer RAM between VGA scan-out
// and a CPU port. Display fetches always win; the CPU fills the gaps.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   hcounter,
  input  logic [10:0]   vcounter,
  input  logic          blank,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  vga_fb_arbiter_if.slave cpu,
  output logic [2:0]    red,
  output logic [2:0]    green,
  output logic [1:0]    blue
);

  logic          display_slot;
  logic [AW-1:0] display_addr;
  ram_owner_t    owner;
  logic          disp_pending;
  logic          ack_is_read;
  logic [7:0]    rdata_hold;
  logic [7:0]    nxt_pix;
  logic [7:0]    cur_pix;
  pixel_t        pix_out;
  logic          load_cur;

  vga_fb_addr_gen #(.AW(AW)) u_addr_gen (
    .hcounter     (hcounter),
    .vcounter     (vcounter),
    .display_slot (display_slot),
    .display_addr (display_addr)
  );

  // Arbitration: display first, then a CPU request not already being acked.
  always_comb begin
    owner = OWN_IDLE;
    if (rst)
      owner = OWN_IDLE;
    else if (display_slot)
      owner = OWN_DISP;
    else if (cpu.cpu_req && !cpu.cpu_ack)
      owner = OWN_CPU;
  end

  // Drive the RAM port straight from this cycle's winner.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (owner == OWN_DISP) begin
      ram_en   = 1'b1;
      ram_addr = display_addr;
    end else if (owner == OWN_CPU) begin
      ram_en    = 1'b1;
      ram_we    = cpu.cpu_we;
      ram_addr  = cpu.cpu_addr;
      ram_wdata = cpu.cpu_wdata;
    end
  end

  // Track what the RAM will return next cycle and acknowledge the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_pending <= 1'b0;
      cpu.cpu_ack  <= 1'b0;
      ack_is_read  <= 1'b0;
      rdata_hold   <= '0;
    end else begin
      disp_pending <= (owner == OWN_DISP);
      cpu.cpu_ack  <= (owner == OWN_CPU);
      ack_is_read  <= (owner == OWN_CPU) && !cpu.cpu_we;
      if (ack_is_read)
        rdata_hold <= ram_rdata;
    end
  end

  // The RAM only presents read data during the ack cycle, so the word is
  // passed through then and held afterwards.
  assign cpu.cpu_rdata = ack_is_read ? ram_rdata : rdata_hold;

  assign load_cur = ((hcounter[1:0] == 2'b11) && (hcounter < HLINES)) ||
                    (hcounter == HMAX);

  // Two-stage pixel pipeline plus the blanked output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_pix <= '0;
      cur_pix <= '0;
      pix_out <= '0;
    end else begin
      if (disp_pending)
        nxt_pix <= ram_rdata;
      if (load_cur)
        cur_pix <= nxt_pix;
      pix_out <= blank ? '0 : pixel_t'(cur_pix);
    end
  end

  assign red   = pix_out.r;
  assign green = pix_out.g;
  assign blue  = pix_out.b;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: drives a vgacontrol-like scan, a synchronous
// RAM and a CPU master, and compares against a behavioural model.
module tb_vga_fb_arbiter;

  localparam int AWT = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [10:0]    hcounter = '0;
  logic [10:0]    vcounter = '0;
  logic           blank = 1'b0;
  logic           ram_en, ram_we;
  logic [AWT-1:0] ram_addr;
  logic [7:0]     ram_wdata;
  logic [7:0]     ram_rdata;
  logic [2:0]     red, green;
  logic [1:0]     blue;

  vga_fb_arbiter_if #(.AW(AWT)) cpu ();

  vga_fb_arbiter #(.AW(AWT)) dut (
    .clk       (clk),
    .rst       (rst),
    .hcounter  (hcounter),
    .vcounter  (vcounter),
    .blank     (blank),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .cpu       (cpu.slave),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  logic [7:0] ram_mem [0:32767];
  logic [7:0] ref_mem [0:32767];
  int hc = 0;
  int vc = 0;
  int passed = 0;
  int total = 0;

  // Synchronous single-port RAM: read data appears the cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we)
        ram_mem[ram_addr] = ram_wdata;
      else
        ram_rdata <= ram_mem[ram_addr];
    end
  end

  function automatic bit model_slot(int h, int v);
    int vn = (v == 525) ? 0 : v + 1;
    int k = (h + 3) / 4;
    if (v < 480 && (h + 3) % 4 == 0 && k >= 1 && k <= 159) return 1'b1;
    if (h == 798 && vn < 480) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_addr(int h, int v);
    int vn = (v == 525) ? 0 : v + 1;
    if (h == 798) return (vn / 4) * 160;
    return (v / 4) * 160 + (h + 3) / 4;
  endfunction

  function automatic logic [7:0] model_pixel(int h, int v);
    if (h >= 640 || v >= 480) return 8'h00;
    return ref_mem[(v / 4) * 160 + h / 4];
  endfunction

  task automatic drive_counters();
    hcounter = 11'(hc);
    vcounter = 11'(vc);
    blank    = (hc >= 640) || (vc >= 480);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (hc == 800) begin
      hc = 0;
      vc = (vc == 525) ? 0 : vc + 1;
    end else begin
      hc = hc + 1;
    end
    drive_counters();
  endtask

  task automatic set_pos(int h, int v);
    hc = h;
    vc = v;
    drive_counters();
  endtask

  task automatic cpu_idle();
    cpu.cpu_req   = 1'b0;
    cpu.cpu_we    = 1'b0;
    cpu.cpu_addr  = '0;
    cpu.cpu_wdata = '0;
  endtask

  task automatic cpu_drive(logic we, int addr, logic [7:0] data);
    cpu.cpu_req   = 1'b1;
    cpu.cpu_we    = we;
    cpu.cpu_addr  = AWT'(addr);
    cpu.cpu_wdata = data;
  endtask

  task automatic test_reset();
    logic [7:0] exp_pix;
    cpu_idle();
    set_pos(0, 0);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ram_en, cpu.cpu_ack, red, green, blue} !== 10'd0) begin
      $display("[TB] FAIL por_outputs: got %b expected 0", {ram_en, cpu.cpu_ack, red, green, blue});
    end else passed++;
    repeat (3) next_cycle();
    rst = 1'b0;
    for (int i = 320; i < 360; i++) begin
      ram_mem[i] = 8'hFF;
      ref_mem[i] = 8'hFF;
    end
    set_pos(80, 8);
    while (hc != 104) next_cycle();
    cpu_drive(1'b1, 7, 8'h5A);
    ref_mem[7] = 8'h5A;
    next_cycle();
    #1;
    exp_pix = model_pixel(104, 8);
    total++;
    if (cpu.cpu_ack !== 1'b1) $display("[TB] FAIL pre_reset_ack: got %b expected 1", cpu.cpu_ack);
    else passed++;
    total++;
    if (ram_en !== 1'b1 || ram_addr !== AWT'(model_addr(105, 8)))
      $display("[TB] FAIL pre_reset_slot: got en=%b addr=%0d expected en=1 addr=%0d", ram_en, ram_addr, model_addr(105, 8));
    else passed++;
    total++;
    if (red !== exp_pix[7:5]) $display("[TB] FAIL pre_reset_red: got %0d expected %0d", red, exp_pix[7:5]);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== '0)
      $display("[TB] FAIL reset_ram_port: got en=%b we=%b addr=%0d wdata=%h expected all 0", ram_en, ram_we, ram_addr, ram_wdata);
    else passed++;
    total++;
    if (cpu.cpu_ack !== 1'b0 || cpu.cpu_rdata !== 8'h00)
      $display("[TB] FAIL reset_cpu_port: got ack=%b rdata=%h expected 0/00", cpu.cpu_ack, cpu.cpu_rdata);
    else passed++;
    total++;
    if ({red, green, blue} !== 8'h00)
      $display("[TB] FAIL reset_rgb: got %h expected 00", {red, green, blue});
    else passed++;
    cpu_idle();
    repeat (2) next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      #1;
      total++;
      if (cpu.cpu_ack !== 1'b0) $display("[TB] FAIL ack_after_reset: got %b expected 0", cpu.cpu_ack);
      else passed++;
    end
  endtask

  task automatic test_video();
    int ph, pv;
    logic [7:0] exp_pix;
    for (int i = 0; i < 320; i++) begin
      ref_mem[i] = 8'($urandom);
      ram_mem[i] = ref_mem[i];
    end
    ref_mem[0] = 8'hE0; ram_mem[0] = 8'hE0;
    ref_mem[1] = 8'h1C; ram_mem[1] = 8'h1C;
    cpu_idle();
    set_pos(790, 525);
    while (!(vc == 1 && hc == 40)) begin
      #1;
      total++;
      if (model_slot(hc, vc)) begin
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AWT'(model_addr(hc, vc)))
          $display("[TB] FAIL slot_h%0d_v%0d: got en=%b we=%b addr=%0d expected en=1 we=0 addr=%0d",
                   hc, vc, ram_en, ram_we, ram_addr, model_addr(hc, vc));
        else passed++;
      end else begin
        if (ram_en !== 1'b0)
          $display("[TB] FAIL noslot_h%0d_v%0d: got en=%b expected 0", hc, vc, ram_en);
        else passed++;
      end
      if (hc == 798 && vc == 525) begin
        total++;
        if (ram_addr !== AWT'(0)) $display("[TB] FAIL wrap_group0_addr: got %0d expected 0", ram_addr);
        else passed++;
      end
      ph = hc;
      pv = vc;
      next_cycle();
      exp_pix = model_pixel(ph, pv);
      total++;
      if ({red, green, blue} !== exp_pix)
        $display("[TB] FAIL pixel_h%0d_v%0d: got %h expected %h", ph, pv, {red, green, blue}, exp_pix);
      else passed++;
      if (pv == 0 && (ph == 2 || ph == 5)) begin
        total++;
        if ((ph == 2 && red !== 3'd7) || (ph == 5 && green !== 3'd7))
          $display("[TB] FAIL group_colour_h%0d: got r=%0d g=%0d expected 7", ph, red, green);
        else passed++;
      end
    end
  endtask

  task automatic test_cpu_blank_line();
    cpu_idle();
    set_pos(100, 500);
    next_cycle();
    cpu_drive(1'b1, 5, 8'hFF);
    #1;
    total++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AWT'(5) || ram_wdata !== 8'hFF)
      $display("[TB] FAIL blank_write_port: got en=%b we=%b addr=%0d wdata=%h expected 1/1/5/ff", ram_en, ram_we, ram_addr, ram_wdata);
    else passed++;
    ref_mem[5] = 8'hFF;
    next_cycle();
    #1;
    total++;
    if (cpu.cpu_ack !== 1'b1) $display("[TB] FAIL blank_write_ack: got %b expected 1", cpu.cpu_ack);
    else passed++;
    cpu_idle();
    next_cycle();
    #1;
    total++;
    if (cpu.cpu_ack !== 1'b0) $display("[TB] FAIL ack_single_pulse: got %b expected 0", cpu.cpu_ack);
    else passed++;
    cpu_drive(1'b0, 5, 8'h00);
    #1;
    total++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AWT'(5))
      $display("[TB] FAIL blank_read_port: got en=%b we=%b addr=%0d expected 1/0/5", ram_en, ram_we, ram_addr);
    else passed++;
    next_cycle();
    #1;
    total++;
    if (cpu.cpu_ack !== 1'b1 || cpu.cpu_rdata !== ref_mem[5])
      $display("[TB] FAIL blank_read_data: got ack=%b rdata=%h expected 1/%h", cpu.cpu_ack, cpu.cpu_rdata, ref_mem[5]);
    else passed++;
    cpu_idle();
    next_cycle();
  endtask

  task automatic test_contention();
    int addr = 200 + int'($urandom_range(0, 99));
    logic [7:0] data = 8'($urandom);
    cpu_idle();
    set_pos(0, 4);
    next_cycle();
    cpu_drive(1'b1, addr, data);
    #1;
    total++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AWT'(161))
      $display("[TB] FAIL contention_display_wins: got en=%b we=%b addr=%0d expected 1/0/161", ram_en, ram_we, ram_addr);
    else passed++;
    next_cycle();
    #1;
    total++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AWT'(addr) || cpu.cpu_ack !== 1'b0)
      $display("[TB] FAIL contention_cpu_h2: got en=%b we=%b addr=%0d ack=%b expected 1/1/%0d/0", ram_en, ram_we, ram_addr, cpu.cpu_ack, addr);
    else passed++;
    ref_mem[addr] = data;
    next_cycle();
    #1;
    total++;
    if (cpu.cpu_ack !== 1'b1) $display("[TB] FAIL contention_ack_h3: got %b expected 1", cpu.cpu_ack);
    else passed++;
    cpu_idle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int ack_cyc [8];
    int nacks = 0;
    int idx = 0;
    logic [7:0] data [4];
    for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
    set_pos(10, 490);
    cpu_drive(1'b1, 64, data[0]);
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (ram_en && ram_we && idx < 4) begin
        total++;
        if (ram_addr !== AWT'(64 + idx) || ram_wdata !== data[idx])
          $display("[TB] FAIL b2b_write%0d: got addr=%0d data=%h expected %0d/%h", idx, ram_addr, ram_wdata, 64 + idx, data[idx]);
        else passed++;
      end
      if (cpu.cpu_ack) begin
        if (nacks < 8) ack_cyc[nacks] = cyc;
        nacks++;
        if (idx < 4) ref_mem[64 + idx] = data[idx];
        idx++;
        if (idx < 4) cpu_drive(1'b1, 64 + idx, data[idx]);
        else cpu_idle();
      end
      next_cycle();
    end
    total++;
    if (nacks !== 4) $display("[TB] FAIL b2b_ack_count: got %0d expected 4", nacks);
    else passed++;
    if (nacks >= 1) begin
      total++;
      if (ack_cyc[0] !== 1) $display("[TB] FAIL b2b_first_ack: got cycle %0d expected 1", ack_cyc[0]);
      else passed++;
    end
    for (int i = 1; i < 4 && i < nacks; i++) begin
      total++;
      if (ack_cyc[i] - ack_cyc[i-1] !== 2)
        $display("[TB] FAIL b2b_spacing%0d: got %0d expected 2", i, ack_cyc[i] - ack_cyc[i-1]);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic we = 1'($urandom_range(0, 1));
      int addr = int'($urandom_range(0, 47));
      logic [7:0] data = 8'($urandom);
      int h0, v0, exp_lat;
      int got_lat = 0;
      logic [7:0] got_rdata = 8'h00;
      set_pos(int'($urandom_range(0, 800)), int'($urandom_range(0, 525)));
      h0 = hc;
      v0 = vc;
      exp_lat = model_slot(h0, v0) ? 2 : 1;
      cpu_drive(we, addr, data);
      for (int c = 0; c < 6 && got_lat == 0; c++) begin
        #1;
        if (c > 0 && cpu.cpu_ack) begin
          got_lat = c;
          got_rdata = cpu.cpu_rdata;
        end else if (c == exp_lat - 1) begin
          total++;
          if (ram_en !== 1'b1 || ram_we !== we || ram_addr !== AWT'(addr))
            $display("[TB] FAIL rnd%0d_accept: got en=%b we=%b addr=%0d expected 1/%b/%0d", n, ram_en, ram_we, ram_addr, we, addr);
          else passed++;
        end else if (c == 0) begin
          total++;
          if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== AWT'(model_addr(h0, v0)))
            $display("[TB] FAIL rnd%0d_display_first: got en=%b we=%b addr=%0d expected 1/0/%0d", n, ram_en, ram_we, ram_addr, model_addr(h0, v0));
          else passed++;
        end
        if (got_lat == 0) next_cycle();
      end
      total++;
      if (got_lat !== exp_lat)
        $display("[TB] FAIL rnd%0d_latency h=%0d v=%0d: got %0d expected %0d", n, h0, v0, got_lat, exp_lat);
      else passed++;
      if (got_lat != 0) begin
        if (we) begin
          ref_mem[addr] = data;
        end else begin
          total++;
          if (got_rdata !== ref_mem[addr])
            $display("[TB] FAIL rnd%0d_rdata addr=%0d: got %h expected %h", n, addr, got_rdata, ref_mem[addr]);
          else passed++;
        end
      end
      cpu_idle();
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    cpu_idle();
    test_reset();
    test_video();
    test_cpu_blank_line();
    test_contention();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
